// File: rtl/pid_io_pkg.sv
// Shared constants and helpers for the plant-side PID responder.
// Holds default widths, the quadrature step encoding and the error saturation bound.
package pid_io_pkg;

    localparam int AW_DEF = 1;
    localparam int EW_DEF = 24;
    localparam int OW_DEF = 12;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_INC     = 2'd1,
        STEP_DEC     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } quad_step_e;

    // Largest error magnitude; symmetric so the most-negative code never appears.
    function automatic longint err_bound(input int w);
        return (longint'(1) <<< (w - 1)) - 64'sd1;
    endfunction

    // Gray order 00 -> 01 -> 11 -> 10 -> 00 counts up; both bits moving is illegal.
    function automatic quad_step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd;
        case (prev)
            2'b00:   fwd = 2'b01;
            2'b01:   fwd = 2'b11;
            2'b11:   fwd = 2'b10;
            default: fwd = 2'b00;
        endcase
        if (cur == prev) return STEP_NONE;
        if ((cur ^ prev) == 2'b11) return STEP_ILLEGAL;
        if (cur == fwd) return STEP_INC;
        return STEP_DEC;
    endfunction

endpackage

// File: rtl/pid_plant_io_if.sv
// PID controller <-> plant bus: channel address, power strobe and returned error.
interface pid_plant_io_if #(
    parameter int aw = 1,
    parameter int ew = 24,
    parameter int ow = 12
);
    logic [aw-1:0]        a;
    logic                 ce;
    logic signed [ow-1:0] m_k;
    logic signed [ew-1:0] error;

    modport master (output a, output ce, output m_k, input error);
    modport slave  (input a, input ce, input m_k, output error);
endinterface

// File: rtl/pid_plant_io_quad_decoder.sv
// Per-channel quadrature front end: 2-FF synchronizer, optional stability
// filter (PID_ENC_FILTER_EN) and Gray step decoder producing inc/dec/illegal pulses.
module quad_decoder
    import pid_io_pkg::*;
(
    input  logic clk_pid,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic inc,
    output logic dec,
    output logic illegal
);

`ifdef PID_ENC_FILTER_EN
    localparam int fill_len = 4;
`else
    localparam int fill_len = 2;
`endif

    logic [1:0]          sync1, sync2, cur, prev;
    logic [fill_len-1:0] fill;
    logic                valid;
    quad_step_e          step;

    // fill marks when cur carries real pin samples rather than reset zeros.
    always_ff @(posedge clk_pid) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            fill  <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            fill  <= {fill[fill_len-2:0], 1'b1};
        end
    end

`ifdef PID_ENC_FILTER_EN
    logic [1:0] hist1, hist2, held, stable;

    always_comb begin
        stable = ~(sync2 ^ hist1) & ~(hist1 ^ hist2);
        cur    = (stable & sync2) | (~stable & held);
    end

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            hist1 <= 2'b00;
            hist2 <= 2'b00;
            held  <= 2'b00;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            held  <= cur;
        end
    end
`else
    assign cur = sync2;
`endif

    // The first real sample only seeds prev; counting starts on the next one.
    always_ff @(posedge clk_pid) begin
        if (reset) begin
            prev  <= 2'b00;
            valid <= 1'b0;
        end else if (valid) begin
            prev <= cur;
        end else if (fill[fill_len-1]) begin
            prev  <= cur;
            valid <= 1'b1;
        end
    end

    always_comb begin
        step    = quad_step(prev, cur);
        inc     = valid && (step == STEP_INC);
        dec     = valid && (step == STEP_DEC);
        illegal = valid && (step == STEP_ILLEGAL);
    end

endmodule

// File: rtl/pid_plant_io.sv
// Plant-side responder: encoder positions, setpoints, saturated error for the
// addressed channel, power latch and sign/magnitude PWM. Filter option: PID_ENC_FILTER_EN.
module pid_plant_io
    import pid_io_pkg::*;
#(
    parameter int aw = AW_DEF,
    parameter int an = 1 << aw,
    parameter int ew = EW_DEF,
    parameter int ow = OW_DEF
) (
    input  logic                 clk_pid,
    input  logic                 reset,
    pid_plant_io_if.slave        pid,
    input  logic [an-1:0]        enc_a,
    input  logic [an-1:0]        enc_b,
    input  logic                 sp_we,
    input  logic [aw-1:0]        sp_addr,
    input  logic signed [ew-1:0] sp_data,
    output logic signed [ew-1:0] pos_data,
    input  logic                 err_clr,
    output logic [an-1:0]        enc_err,
    output logic [an-1:0]        pwm_out,
    output logic [an-1:0]        dir_out
);

    localparam logic signed [ew:0]   err_hi  = (ew+1)'(err_bound(ew));
    localparam logic signed [ew:0]   err_lo  = -err_hi;
    localparam logic signed [ew-1:0] pos_one = {{(ew-1){1'b0}}, 1'b1};
    localparam logic signed [ow-1:0] pow_min = {1'b1, {(ow-1){1'b0}}};
    localparam logic [ow-2:0]        cnt_one = {{(ow-2){1'b0}}, 1'b1};

    logic [an-1:0]        inc, dec, illegal;
    logic signed [ew-1:0] position [an];
    logic signed [ew-1:0] setpoint [an];
    logic signed [ow-1:0] power    [an];
    logic [ow-2:0]        mag      [an];
    logic [ow-2:0]        cnt;
    logic signed [ew:0]   diff;
    logic signed [ew-1:0] err_next;

    genvar gi;
    generate
        for (gi = 0; gi < an; gi++) begin : g_dec
            quad_decoder u_dec (
                .clk_pid (clk_pid),
                .reset   (reset),
                .enc_a   (enc_a[gi]),
                .enc_b   (enc_b[gi]),
                .inc     (inc[gi]),
                .dec     (dec[gi]),
                .illegal (illegal[gi])
            );
        end
    endgenerate

    // Illegal transitions take priority over err_clr so no event is lost.
    always_ff @(posedge clk_pid) begin
        if (reset) begin
            for (int i = 0; i < an; i++) begin
                position[i] <= '0;
                enc_err[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < an; i++) begin
                if (inc[i])      position[i] <= position[i] + pos_one;
                else if (dec[i]) position[i] <= position[i] - pos_one;
                if (illegal[i])   enc_err[i] <= 1'b1;
                else if (err_clr) enc_err[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        diff = {setpoint[pid.a][ew-1], setpoint[pid.a]} - {position[pid.a][ew-1], position[pid.a]};
        if (diff > err_hi)      err_next = err_hi[ew-1:0];
        else if (diff < err_lo) err_next = err_lo[ew-1:0];
        else                    err_next = diff[ew-1:0];
    end

    // The most-negative power has no positive twin, so it clamps to full scale.
    always_comb begin
        for (int i = 0; i < an; i++) begin
            if (power[i] == pow_min)  mag[i] = '1;
            else if (power[i][ow-1])  mag[i] = (ow-1)'(-power[i]);
            else                      mag[i] = (ow-1)'(power[i]);
        end
    end

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            for (int i = 0; i < an; i++) begin
                setpoint[i] <= '0;
                power[i]    <= '0;
                pwm_out[i]  <= 1'b0;
                dir_out[i]  <= 1'b0;
            end
            cnt       <= '0;
            pid.error <= '0;
            pos_data  <= '0;
        end else begin
            if (sp_we)  setpoint[sp_addr] <= sp_data;
            if (pid.ce) power[pid.a]      <= pid.m_k;
            cnt       <= cnt + cnt_one;
            pid.error <= err_next;
            pos_data  <= position[sp_addr];
            for (int i = 0; i < an; i++) begin
                pwm_out[i] <= (mag[i] > cnt);
                dir_out[i] <= power[i][ow-1];
            end
        end
    end

endmodule
